fifo_stream_reader: RTL and testbench

Drains the read side of a synchronous FIFO and presents the words as a valid/ready stream. Upstream it drives `fifo_rd_en` against `fifo_empty` and absorbs the FIFO's 1-cycle read latency. Downstream it groups beats into fixed-length bursts, asserting `m_last` on the final beat of each burst. It sits between a FIFO and any back-pressuring consumer (serialiser, DMA write port) and sustains 1 beat/cycle.

---
 rtl/stream_pkg.sv | 17 +
 rtl/stream_skid_buf.sv | 51 +++++
 rtl/fifo_stream_reader.sv | 86 ++++++++
 tb/tb_fifo_stream_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the FIFO-to-stream reader and its output buffer.
package stream_pkg;

  localparam int DEPTH      = 2;
  localparam int OCC_W      = $clog2(DEPTH + 1);
  localparam int DEF_DATA_W = 8;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } stream_entry_t;

  function automatic int cnt_w(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order output buffer; head is always the oldest word.
module stream_skid_buf
  import stream_pkg::*;
#(
  parameter type entry_t = stream_entry_t
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output entry_t           head,
  output logic             head_vld
);

  entry_t tail;

  assign head_vld = (occ != '0);

  // A push into an empty buffer lands directly in the head slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) head <= push_entry;
          else           tail <= push_entry;
          occ <= occ + 1'b1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 1'b1;
        end
        2'b11: begin
          if (occ == OCC_W'(DEPTH)) begin
            head <= tail;
            tail <= push_entry;
          end else begin
            head <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency synchronous FIFO into a valid/ready stream with fixed-length bursts.
module fifo_stream_reader
  import stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_LEN  = 4,
  localparam int CNT_W      = cnt_w(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic                  burst_done
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  localparam int               LVL_W    = OCC_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  logic             pop;
  logic             inflight;
  logic [CNT_W-1:0] cap_cnt;
  logic [OCC_W-1:0] occ;
  logic [LVL_W-1:0] level;
  entry_t           cap_entry;
  entry_t           head;
  logic             head_vld;

  assign pop     = m_valid && m_ready;
  assign m_valid = head_vld;
  assign m_data  = head.data;
  assign m_last  = head.last;

  // Committed words (buffered + in flight) after this cycle's pop must leave room for one more.
  assign level      = {1'b0, occ} + LVL_W'(inflight);
  assign fifo_rd_en = !rst && !fifo_empty && (level < LVL_W'(DEPTH) + LVL_W'(pop));

  assign cap_entry.data = fifo_rd_data;
  assign cap_entry.last = (cap_cnt == LAST_IDX);

  stream_skid_buf #(
    .entry_t(entry_t)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_entry(cap_entry),
    .pop       (pop),
    .occ       (occ),
    .head      (head),
    .head_vld  (head_vld)
  );

  // Read-return and burst bookkeeping stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= 1'b0;
      cap_cnt    <= '0;
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      burst_done <= pop && m_last;
      if (inflight) cap_cnt <= (cap_cnt == LAST_IDX) ? '0 : cap_cnt + 1'b1;
      if (pop)      beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
    end
  end

  head_tag_matches_beat: assert property (@(posedge clk) disable iff (rst)
    m_valid |-> (m_last == (beat_cnt == LAST_IDX)));

  // With nothing buffered or in flight, every captured word has been delivered.
  cap_cnt_matches_beat: assert property (@(posedge clk) disable iff (rst)
    (occ == '0 && !inflight) |-> (cap_cnt == beat_cnt));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: FIFO models feed a BURST_LEN=4 and a BURST_LEN=1 reader; a monitor checks every beat.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fifo_empty, fifo_rd_en, m_valid, m_ready, m_last, burst_done;
  logic [7:0] fifo_rd_data [2];
  logic [7:0] m_data [2];
  logic [1:0] bc0;
  logic [0:0] bc1;
  logic [1:0] bc_w [2];

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(4)) dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]),
    .fifo_rd_data(fifo_rd_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(m_data[0]), .m_last(m_last[0]), .beat_cnt(bc0), .burst_done(burst_done[0]));

  fifo_stream_reader #(.DATA_WIDTH(8), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]),
    .fifo_rd_data(fifo_rd_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(m_data[1]), .m_last(m_last[1]), .beat_cnt(bc1), .burst_done(burst_done[1]));

  assign bc_w[0] = bc0;
  assign bc_w[1] = {1'b0, bc1};

  // FIFO models: wr_ptr owned by the stimulus, rd_ptr by the read port.
  logic [7:0] mem [2][1024];
  int         rd_ptr [2] = '{0, 0};
  int         wr_ptr [2] = '{0, 0};

  assign fifo_empty[0] = (rd_ptr[0] == wr_ptr[0]);
  assign fifo_empty[1] = (rd_ptr[1] == wr_ptr[1]);

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (fifo_rd_en[d] && rd_ptr[d] != wr_ptr[d]) begin
        fifo_rd_data[d] <= mem[d][rd_ptr[d] % 1024];
        rd_ptr[d]       <= rd_ptr[d] + 1;
      end
    end
  end

  // Reference: the k-th word pushed since reset (k from 0) is a burst end iff k % BURST_LEN == BURST_LEN-1.
  logic [8:0] exp_q [2][$];
  int         pushed [2] = '{0, 0};
  int         checks = 0;
  int         errors = 0;
  int         exp_beat [2] = '{0, 0};
  int         bd_seen [2] = '{0, 0};
  logic       exp_bd [2] = '{1'b0, 1'b0};
  logic       stall [2] = '{1'b0, 1'b0};
  logic       stall_last [2];
  logic [7:0] stall_data [2];

  function automatic int bl(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_word(input int d, input logic [7:0] w);
    mem[d][wr_ptr[d] % 1024] = w;
    wr_ptr[d]++;
    exp_q[d].push_back({w, (pushed[d] % bl(d)) == bl(d) - 1});
    pushed[d]++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int d, input int budget, input bit rnd);
    int n = 0;
    while (exp_q[d].size() != 0 && n < budget) begin
      m_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step(1);
      n++;
    end
    m_ready[d] = 1'b1;
    chk("drain_empty", 32'(exp_q[d].size()), 32'd0);
  endtask

  task automatic flush_models();
    for (int d = 0; d < 2; d++) begin
      wr_ptr[d] = rd_ptr[d];
      exp_q[d].delete();
      pushed[d] = 0;
    end
  endtask

  // Monitor: compares every transfer and per-cycle burst state with the reference.
  always @(negedge clk) begin
    logic [8:0] e;
    for (int d = 0; d < 2; d++) begin
      chk("rd_while_empty", 32'(fifo_rd_en[d] & fifo_empty[d]), 32'd0);
      if (rst) begin
        exp_beat[d] = 0;
        exp_bd[d]   = 1'b0;
        stall[d]    = 1'b0;
      end else begin
        chk("beat_cnt", 32'(bc_w[d]), 32'(exp_beat[d]));
        chk("burst_done", 32'(burst_done[d]), 32'(exp_bd[d]));
        if (burst_done[d]) bd_seen[d]++;
        if (stall[d]) begin
          chk("stall_valid", 32'(m_valid[d]), 32'd1);
          chk("stall_data", 32'(m_data[d]), 32'(stall_data[d]));
          chk("stall_last", 32'(m_last[d]), 32'(stall_last[d]));
        end
        exp_bd[d] = 1'b0;
        if (m_valid[d] && m_ready[d]) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat dut=%0d actual=%0h required=none", d, m_data[d]);
          end else begin
            e = exp_q[d].pop_front();
            chk("beat_data", 32'(m_data[d]), 32'(e[8:1]));
            chk("beat_last", 32'(m_last[d]), 32'(e[0]));
            exp_beat[d] = (exp_beat[d] + 1) % bl(d);
            exp_bd[d]   = e[0];
          end
        end
        stall[d]      = m_valid[d] && !m_ready[d];
        stall_data[d] = m_data[d];
        stall_last[d] = m_last[d];
      end
    end
  end

  initial begin
    int bd0, bd1, cnt, n, guard;
    rst     = 1'b1;
    m_ready = 2'b00;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(m_valid[d]), 32'd0);
      chk("rst_data", 32'(m_data[d]), 32'd0);
      chk("rst_last", 32'(m_last[d]), 32'd0);
      chk("rst_beat", 32'(bc_w[d]), 32'd0);
      chk("rst_done", 32'(burst_done[d]), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en[d]), 32'd0);
    end

    // Back-to-back burst stream: first beat two cycles after the first read.
    step(1);
    m_ready = 2'b11;
    bd0 = bd_seen[0];
    for (int i = 1; i <= 8; i++) push_word(0, 8'(i));
    @(negedge clk);
    chk("t1_first_rd", 32'(fifo_rd_en[0]), 32'd1);
    chk("t1_valid_k0", 32'(m_valid[0]), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t1_valid_seq", 32'(m_valid[0]), 32'(k >= 2 && k <= 9));
    end
    step(2);
    chk("t1_bursts", 32'(bd_seen[0] - bd0), 32'd2);

    // Stalled consumer: only two reads fit, head holds.
    m_ready[0] = 1'b0;
    for (int i = 0; i < 6; i++) push_word(0, 8'hA0 + 8'(i));
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (fifo_rd_en[0]) cnt++;
    end
    chk("t2_rd_pulses", 32'(cnt), 32'd2);
    chk("t2_hold_valid", 32'(m_valid[0]), 32'd1);
    chk("t2_hold_data", 32'(m_data[0]), 32'hA0);
    step(1);
    drain(0, 100, 1'b0);

    // Random fill and random back-pressure.
    n = 0;
    guard = 0;
    while (n < 200 && guard < 5000) begin
      if ($urandom_range(0, 3) != 0) begin
        push_word(0, 8'($urandom));
        n++;
      end
      m_ready[0] = 1'($urandom_range(0, 1));
      step(1);
      guard++;
    end
    drain(0, 2000, 1'b1);

    // Reset with a full buffer and words still waiting in the FIFO.
    m_ready = 2'b00;
    for (int i = 0; i < 5; i++) push_word(0, 8'hC0 + 8'(i));
    step(6);
    chk("t5_full_valid", 32'(m_valid[0]), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rd_gated", 32'(fifo_rd_en[0]), 32'd0);
    step(1);
    rst = 1'b0;
    flush_models();
    @(negedge clk);
    chk("t5_valid", 32'(m_valid[0]), 32'd0);
    chk("t5_beat", 32'(bc_w[0]), 32'd0);
    chk("t5_rd_en", 32'(fifo_rd_en[0]), 32'd0);
    chk("t5_data", 32'(m_data[0]), 32'd0);
    step(1);
    m_ready = 2'b11;
    for (int i = 0; i < 4; i++) push_word(0, 8'hD0 + 8'(i));
    drain(0, 100, 1'b0);

    // FIFO runs dry mid-burst.
    push_word(0, 8'h31);
    push_word(0, 8'h32);
    step(6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_gap_valid", 32'(m_valid[0]), 32'd0);
      chk("t4_gap_beat", 32'(bc_w[0]), 32'd2);
    end
    step(1);
    push_word(0, 8'h33);
    push_word(0, 8'h34);
    drain(0, 100, 1'b0);

    // Single-beat bursts.
    bd1 = bd_seen[1];
    push_word(1, 8'h55);
    push_word(1, 8'hAA);
    drain(1, 100, 1'b0);
    step(3);
    chk("t6_bursts", 32'(bd_seen[1] - bd1), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
